// File: rtl/ch0re_types.sv
// Shared types for the ch0re execute stage.
// Holds the multiply/divide opcode and FSM state encodings.
package ch0re_types;

    typedef enum logic [2:0] {
        MD_MUL,
        MD_MULH,
        MD_MULHSU,
        MD_MULHU,
        MD_DIV,
        MD_DIVU,
        MD_REM,
        MD_REMU
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_FIX,
        MD_DONE
    } muldiv_state_e;

endpackage

// File: rtl/ch0re_div_core.sv
// Restoring divider: one quotient bit per cycle on unsigned magnitudes.
// Ports: clk, rst_n (sync, active-low); start loads operands; word selects
// a 32-bit dividend; quo/rem are the running results; done is high during
// the final step cycle.
module ch0re_div_core #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem,
    output logic            done
);

    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] dsr;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   trial;
    logic            ge;

    // Top bit of the trial subtraction is the borrow: clear means the
    // shifted remainder was at least the divisor.
    always_comb begin
        trial = {rem, quo[XLEN-1]} - {1'b0, dsr};
        ge    = ~trial[XLEN];
    end

    assign done = (cnt == CW'(1));

    // The word dividend is pre-shifted so its MSB enters first and the
    // 32 quotient bits land in the low half after 32 steps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem <= '0;
            quo <= '0;
            dsr <= '0;
            cnt <= '0;
        end else if (start) begin
            rem <= '0;
            quo <= word ? dividend << (XLEN - 32) : dividend;
            dsr <= divisor;
            cnt <= word ? CW'(32) : CW'(XLEN);
        end else if (cnt != '0) begin
            rem <= ge ? trial[XLEN-1:0] : {rem[XLEN-2:0], quo[XLEN-1]};
            quo <= {quo[XLEN-2:0], ge};
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/ch0re_muldiv.sv
// Iterative RV64M multiply/divide unit for the ch0re execute stage.
// Ports: i_clk, i_rst_n (sync, active-low); request i_valid/o_ready with
// i_op, i_word, i_s1, i_s2; i_kill flushes; response o_valid/i_ready with
// o_res; o_busy is high whenever the FSM is not idle.
module ch0re_muldiv
    import ch0re_types::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 4,
    parameter int DIV_BITS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  muldiv_op_e      i_op,
    input  logic            i_word,
    input  logic [XLEN-1:0] i_s1,
    input  logic [XLEN-1:0] i_s2,
    input  logic            i_kill,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_res,
    output logic            o_busy
);

    localparam int CW      = $clog2(XLEN + 1);
    localparam int MUL_N   = XLEN / MUL_BITS;
    localparam int MULW_N  = (32 + MUL_BITS - 1) / MUL_BITS;
    // After MULW_N steps the product sits shifted up by this amount.
    localparam int MULW_LO = XLEN - MULW_N * MUL_BITS;
    localparam int PW      = XLEN + MUL_BITS;

    generate
        if (DIV_BITS != 1 || XLEN % 2 != 0 || XLEN < 32 ||
            (XLEN / 2) % MUL_BITS != 0) begin : g_bad_cfg
            $error("ch0re_muldiv: unsupported parameter set");
        end
    endgenerate

    muldiv_state_e   state, nxt;
    muldiv_op_e      op_q;
    logic            word_q, neg_q, na_q, spec_q;
    logic [XLEN-1:0] mag_a_q;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]   cnt;

    logic            is_div_in, sg1, sg2, word_in, na, nb;
    logic            div0, ovf, spec_in, accept;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_v;

    logic [XLEN-1:0] div_quo, div_rem;
    logic            div_done, is_div_q, last;
    logic [PW-1:0]   hi_sum;
    logic [2*XLEN-1:0] mul_nxt, prod;
    logic [XLEN-1:0] qf, rf, res, fix_res;

    // Request decode: operand extension, magnitudes and early-out cases.
    always_comb begin
        is_div_in = i_op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
        sg1       = i_op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        sg2       = i_op inside {MD_MULH, MD_DIV, MD_REM};
        word_in   = i_word & (i_op == MD_MUL || is_div_in);
        a_ext     = word_in ? {{(XLEN-32){sg1 & i_s1[31]}}, i_s1[31:0]} : i_s1;
        b_ext     = word_in ? {{(XLEN-32){sg2 & i_s2[31]}}, i_s2[31:0]} : i_s2;
        na        = sg1 & a_ext[XLEN-1];
        nb        = sg2 & b_ext[XLEN-1];
        mag_a     = na ? -a_ext : a_ext;
        mag_b     = nb ? -b_ext : b_ext;
        min_v     = word_in ? {{(XLEN-31){1'b1}}, 31'b0}
                            : {1'b1, {(XLEN-1){1'b0}}};
        div0      = is_div_in & (b_ext == '0);
        ovf       = is_div_in & sg2 & (a_ext == min_v) & (b_ext == '1);
        spec_in   = div0 | ovf;
        accept    = (state == MD_IDLE) & i_valid & ~i_kill;
    end

    // Shift-add step: MUL_BITS multiplier bits from the bottom of acc.
    always_comb begin
        hi_sum  = PW'(acc[2*XLEN-1:XLEN])
                + PW'(mag_a_q) * PW'(acc[MUL_BITS-1:0]);
        mul_nxt = {hi_sum, acc[XLEN-1:MUL_BITS]};
    end

    // Sign correction and result selection. Early-out results were
    // parked in acc as {remainder, quotient}.
    always_comb begin
        is_div_q = op_q inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
        last     = is_div_q ? div_done : (cnt == CW'(1));
        prod     = neg_q ? -acc : acc;
        qf       = neg_q ? -div_quo : div_quo;
        rf       = na_q ? -div_rem : div_rem;
        res      = '0;
        unique case (op_q)
            MD_MUL: res = word_q ? {{(XLEN-32){1'b0}}, prod[MULW_LO +: 32]}
                                 : prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: res = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU: res = spec_q ? acc[XLEN-1:0] : qf;
            MD_REM, MD_REMU: res = spec_q ? acc[2*XLEN-1:XLEN] : rf;
            default: res = '0;
        endcase
        fix_res = word_q ? {{(XLEN-32){res[31]}}, res[31:0]} : res;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            MD_IDLE: if (accept) nxt = spec_in ? MD_FIX : MD_BUSY;
            MD_BUSY: if (last) nxt = MD_FIX;
            MD_FIX:  nxt = MD_DONE;
            MD_DONE: if (i_ready) nxt = MD_IDLE;
            default: nxt = MD_IDLE;
        endcase
        if (i_kill) nxt = MD_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= MD_IDLE;
        else          state <= nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            op_q    <= MD_MUL;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            na_q    <= 1'b0;
            spec_q  <= 1'b0;
            mag_a_q <= '0;
            acc     <= '0;
            cnt     <= '0;
            o_res   <= '0;
        end else begin
            if (accept) begin
                op_q    <= i_op;
                word_q  <= word_in;
                neg_q   <= na ^ nb;
                na_q    <= na;
                spec_q  <= spec_in;
                mag_a_q <= mag_a;
                if (ovf)       acc <= {{XLEN{1'b0}}, a_ext};
                else if (div0) acc <= {a_ext, {XLEN{1'b1}}};
                else           acc <= {{XLEN{1'b0}}, mag_b};
                if (is_div_in) cnt <= word_in ? CW'(32) : CW'(XLEN);
                else           cnt <= word_in ? CW'(MULW_N) : CW'(MUL_N);
            end else if (state == MD_BUSY) begin
                cnt <= cnt - CW'(1);
                if (!is_div_q) acc <= mul_nxt;
            end
            if (state == MD_FIX && !i_kill) o_res <= fix_res;
        end
    end

    ch0re_div_core #(.XLEN(XLEN)) u_div (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .start    (accept & is_div_in & ~spec_in),
        .word     (word_in),
        .dividend (mag_a),
        .divisor  (mag_b),
        .quo      (div_quo),
        .rem      (div_rem),
        .done     (div_done)
    );

    assign o_ready = (state == MD_IDLE);
    assign o_valid = (state == MD_DONE);
    assign o_busy  = (state != MD_IDLE);

endmodule

// File: tb/tb_ch0re_muldiv.sv
// Self-checking bench for ch0re_muldiv (XLEN=64, MUL_BITS=4).
// Directed cases plus randomized ops against an arithmetic reference.
module tb_ch0re_muldiv;
    import ch0re_types::*;

    logic        clk = 1'b0;
    logic        rst_n, i_valid, o_ready, i_word, i_kill;
    logic        o_valid, i_ready, o_busy;
    muldiv_op_e  i_op;
    logic [63:0] i_s1, i_s2, o_res;
    int          ntests = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    ch0re_muldiv #(.XLEN(64), .MUL_BITS(4), .DIV_BITS(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_word  (i_word),
        .i_s1    (i_s1),
        .i_s2    (i_s2),
        .i_kill  (i_kill),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res),
        .o_busy  (o_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(muldiv_op_e op, logic w,
                                          logic [63:0] a, logic [63:0] b);
        logic signed [127:0] pa, pb, p;
        logic signed [63:0]  sa, sb;
        logic signed [31:0]  wa, wb;
        logic [31:0]         r32;
        logic [63:0]         r;
        logic                ww, wovf, fovf;
        ww   = w && (op inside {MD_MUL, MD_DIV, MD_DIVU, MD_REM, MD_REMU});
        wa   = a[31:0];
        wb   = b[31:0];
        sa   = a;
        sb   = b;
        wovf = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        fovf = (a == 64'h8000_0000_0000_0000) && (b == '1);
        r32  = '0;
        r    = '0;
        p    = '0;
        if (ww) begin
            case (op)
                MD_MUL: r32 = wa * wb;
                MD_DIV: begin
                    if (wb == 0)   r32 = '1;
                    else if (wovf) r32 = wa;
                    else           r32 = wa / wb;
                end
                MD_DIVU: begin
                    if (b[31:0] == 0) r32 = '1;
                    else              r32 = a[31:0] / b[31:0];
                end
                MD_REM: begin
                    if (wb == 0)   r32 = wa;
                    else if (wovf) r32 = '0;
                    else           r32 = wa % wb;
                end
                MD_REMU: begin
                    if (b[31:0] == 0) r32 = a[31:0];
                    else              r32 = a[31:0] % b[31:0];
                end
                default: r32 = '0;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (op)
                MD_MUL: r = a * b;
                MD_MULH: begin
                    pa = sa; pb = sb; p = pa * pb; r = p[127:64];
                end
                MD_MULHSU: begin
                    pa = sa; pb = {64'd0, b}; p = pa * pb; r = p[127:64];
                end
                MD_MULHU: begin
                    p = {64'd0, a} * {64'd0, b}; r = p[127:64];
                end
                MD_DIV: begin
                    if (b == 0)    r = '1;
                    else if (fovf) r = a;
                    else           r = sa / sb;
                end
                MD_DIVU: r = (b == 0) ? '1 : a / b;
                MD_REM: begin
                    if (b == 0)    r = a;
                    else if (fovf) r = '0;
                    else           r = sa % sb;
                end
                MD_REMU: r = (b == 0) ? a : a % b;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    function automatic int exp_lat(muldiv_op_e op, logic w,
                                   logic [63:0] a, logic [63:0] b);
        logic z, o;
        if (!(op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}))
            return ((w && op == MD_MUL) ? 32 : 64) / 4 + 2;
        z = w ? (b[31:0] == 0) : (b == 0);
        o = (op inside {MD_DIV, MD_REM}) &&
            (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
               : (a == 64'h8000_0000_0000_0000 && b == '1));
        return (z || o) ? 2 : (w ? 32 : 64) + 2;
    endfunction

    task automatic run(input muldiv_op_e op, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input int stall, input string tag);
        int lat;
        i_op = op; i_word = w; i_s1 = a; i_s2 = b; i_valid = 1'b1;
        check({tag, " rdy"}, 64'(o_ready), 64'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " lat"}, 64'(lat), 64'(exp_lat(op, w, a, b)));
        check({tag, " res"}, o_res, model(op, w, a, b));
        if (stall > 0) begin
            repeat (stall) begin @(posedge clk); #1; end
            check({tag, " hold"}, o_res, model(op, w, a, b));
            check({tag, " hold vr"}, 64'({o_valid, o_ready}), 64'(2'b10));
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check({tag, " ack"}, 64'({o_valid, o_ready, o_busy}), 64'(3'b010));
    endtask

    initial begin : main
        muldiv_op_e  op;
        logic        w, seen;
        logic [63:0] a, b;
        int          sel;
        rst_n = 1'b0; i_valid = 1'b0; i_word = 1'b0; i_kill = 1'b0;
        i_ready = 1'b0; i_op = MD_MUL; i_s1 = '0; i_s2 = '0;
        @(posedge clk); #1;
        check("reset vrb", 64'({o_valid, o_ready, o_busy}), 64'(3'b010));
        check("reset res", o_res, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(MD_MUL, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0, "mul");
        check("mul lit", o_res, 64'hFFFF_FFFF_FFFF_FFEB);
        run(MD_MULHU, 0, '1, '1, 0, "mulhu");
        check("mulhu lit", o_res, 64'hFFFF_FFFF_FFFF_FFFE);
        run(MD_MULHSU, 0, '1, 64'd2, 0, "mulhsu");
        run(MD_MULH, 0, 64'h8000_0000_0000_0000, 64'd3, 0, "mulh");
        run(MD_MULH, 1, 64'h8000_0000_0000_0000, 64'd3, 0, "mulh w");
        run(MD_MUL, 1, 64'h1111_2222_8000_0001, 64'd5, 0, "mulw");
        run(MD_DIV, 0, 64'd100, 64'd0, 0, "div0");
        run(MD_REM, 0, 64'd100, 64'd0, 0, "rem0");
        check("rem0 lit", o_res, 64'd100);
        run(MD_DIV, 0, 64'h8000_0000_0000_0000, '1, 0, "divovf");
        run(MD_REM, 0, 64'h8000_0000_0000_0000, '1, 0, "removf");
        run(MD_DIV, 1, 64'h1234_5678_8000_0000, 64'd2, 0, "divw");
        check("divw lit", o_res, 64'hFFFF_FFFF_C000_0000);
        run(MD_REMU, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, "remu");
        run(MD_REM, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, "rem neg");
        run(MD_DIVU, 1, 64'hAAAA_AAAA_0000_0007, 64'd0, 0, "divuw0");
        run(MD_REMU, 1, 64'h0000_0000_F000_0000, 64'd0, 0, "remuw0");
        run(MD_MUL, 0, 64'h0123_4567_89AB_CDEF, 64'd77, 5, "bp");

        // Kill in the 10th BUSY cycle of a divide.
        i_op = MD_DIV; i_word = 1'b0; i_s1 = 64'd1000; i_s2 = 64'd7;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("kill pre", 64'({o_valid, o_busy}), 64'(2'b01));
        i_kill = 1'b1;
        @(posedge clk); #1;
        i_kill = 1'b0;
        check("kill idle", 64'({o_valid, o_ready, o_busy}), 64'(3'b010));
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (o_valid) seen = 1'b1;
        end
        check("kill no valid", 64'(seen), 64'd0);

        // A request alongside kill is dropped.
        i_op = MD_MUL; i_s1 = 64'd3; i_s2 = 64'd4;
        i_valid = 1'b1; i_kill = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_kill = 1'b0;
        check("kill vs valid", 64'(o_busy), 64'd0);

        // Reset in the middle of a multiply.
        i_op = MD_MUL; i_s1 = 64'hDEAD_BEEF; i_s2 = 64'h1234_5678;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst mid vrb", 64'({o_valid, o_ready, o_busy}), 64'(3'b010));
        check("rst mid res", o_res, 64'd0);
        run(MD_MUL, 0, 64'd3, 64'd5, 0, "mul post rst");
        check("mul post rst lit", o_res, 64'd15);

        for (int i = 0; i < 60; i++) begin
            op  = muldiv_op_e'(3'($urandom_range(0, 7)));
            w   = 1'($urandom_range(0, 1));
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                b = w ? {$urandom, 32'd0} : 64'd0;
            end else if (sel == 1) begin
                a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
            end else if (sel == 2) begin
                b = 64'($urandom_range(1, 9));
            end
            run(op, w, a, b, $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
